// File: rtl/demux_lane_packer.sv
// Reassembles serial bits from an upstream 1-to-4 demux into per-lane words.
// Completed words are handed to a single output register by a round-robin arbiter.
module demux_lane_packer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [1:0]        select,
  input  logic [3:0]        lane_bits,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_lane,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        overflow,
  input  logic              ovf_clr
);
  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  // The oldest bit of a completed word is never shifted further, so the
  // shift register only keeps DATA_W-1 bits.
  logic [DATA_W-2:0] shift_r [4];
  logic [CNT_W-1:0]  cnt_r   [4];
  logic [DATA_W-1:0] hold_r  [4];
  logic [3:0]        pending;
  logic [1:0]        rr;

  logic              load;
  logic              any_pend;
  logic [1:0]        grant;
  logic              in_bit;
  logic [DATA_W-1:0] word;
  logic              word_done;
  logic              sel_drain;

  always_comb begin
    load     = !out_valid || out_ready;
    any_pend = 1'b0;
    grant    = rr;
    for (int unsigned k = 0; k < 4; k++) begin
      if (!any_pend && pending[rr + 2'(k)]) begin
        any_pend = 1'b1;
        grant    = rr + 2'(k);
      end
    end
    in_bit    = lane_bits[select];
    word      = {shift_r[select], in_bit};
    word_done = in_valid && (cnt_r[select] == LAST);
    sel_drain = load && any_pend && (grant == select);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 4; i++) begin
        shift_r[i] <= '0;
        cnt_r[i]   <= '0;
        hold_r[i]  <= '0;
      end
      pending   <= '0;
      rr        <= '0;
      out_valid <= 1'b0;
      out_lane  <= '0;
      out_data  <= '0;
      overflow  <= '0;
    end else begin
      if (load) begin
        if (any_pend) begin
          out_valid      <= 1'b1;
          out_lane       <= grant;
          out_data       <= hold_r[grant];
          rr             <= grant + 2'd1;
          pending[grant] <= 1'b0;
        end else begin
          out_valid <= 1'b0;
        end
      end

      if (ovf_clr) overflow <= '0;

      // Later assignments win: a completing word re-arms pending even if the
      // same lane was just drained, and a new overflow beats ovf_clr.
      if (in_valid) begin
        shift_r[select] <= word[DATA_W-2:0];
        if (word_done) begin
          cnt_r[select] <= '0;
          if (pending[select] && !sel_drain) begin
            overflow[select] <= 1'b1;
          end else begin
            hold_r[select]  <= word;
            pending[select] <= 1'b1;
          end
        end else begin
          cnt_r[select] <= cnt_r[select] + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_demux_lane_packer.sv
// Directed bench for demux_lane_packer: vector table plus hand-written
// multi-cycle sequences for backpressure, overflow and reset corners.
module tb_demux_lane_packer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [1:0] select = '0;
  logic [3:0] lane_bits = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [1:0] out_lane;
  logic [7:0] out_data;
  logic [3:0] overflow;
  logic       ovf_clr = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  demux_lane_packer #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .select(select),
    .lane_bits(lane_bits), .out_valid(out_valid), .out_ready(out_ready),
    .out_lane(out_lane), .out_data(out_data), .overflow(overflow),
    .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       iv;
    logic [1:0] sel;
    logic       bitv;
    logic       rdy;
    logic       clr;
    logic       ev;
    logic [1:0] elane;
    logic [7:0] edata;
    logic [3:0] eovf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic iv, logic [1:0] sel, logic bitv,
                              logic rdy, logic clr, logic ev, logic [1:0] elane,
                              logic [7:0] edata, logic [3:0] eovf);
    vec_t v;
    v.rst = r; v.iv = iv; v.sel = sel; v.bitv = bitv; v.rdy = rdy; v.clr = clr;
    v.ev = ev; v.elane = elane; v.edata = edata; v.eovf = eovf;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // The addressed lane carries the bit; every other lane carries its inverse.
  function automatic logic [3:0] lanes_for(logic [1:0] lane, logic b);
    logic [3:0] one_hot;
    one_hot = 4'b0001 << lane;
    return b ? one_hot : ~one_hot;
  endfunction

  task automatic send_word(input logic [1:0] lane, input logic [7:0] w,
                           input logic rdy, input logic rdy_last, input logic clr_last);
    for (int b = 7; b >= 0; b--) begin
      rst       = 1'b0;
      in_valid  = 1'b1;
      select    = lane;
      lane_bits = lanes_for(lane, w[b]);
      out_ready = (b == 0) ? rdy_last : rdy;
      ovf_clr   = (b == 0) ? clr_last : 1'b0;
      step();
    end
    in_valid = 1'b0;
    ovf_clr  = 1'b0;
  endtask

  task automatic idle(input logic rdy, input logic clr);
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = rdy;
    ovf_clr   = clr;
    step();
    ovf_clr   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; ovf_clr = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic chk_out(input string name, input logic ev, input logic [1:0] el,
                         input logic [7:0] ed, input logic [3:0] eo);
    chk({name, ".valid"}, 32'(out_valid), 32'(ev));
    chk({name, ".ovf"}, 32'(overflow), 32'(eo));
    if (ev) begin
      chk({name, ".lane"}, 32'(out_lane), 32'(el));
      chk({name, ".data"}, 32'(out_data), 32'(ed));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] w;
    logic [7:0] ws [3];
    logic [1:0] ls [3];
    logic [1:0] q_lane [$];
    logic [7:0] q_data [$];
    logic [1:0] exp_lane [4];
    logic [7:0] exp_data [4];
    logic       hold_v;
    logic [1:0] hold_l;
    logic [7:0] hold_d;
    vec_t v;

    // Reset state, then a single word B2 on lane 2.
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 4'h0));
    w = 8'hB2;
    for (int b = 7; b >= 0; b--)
      tbl.push_back(mk(0, 1, 2, w[b], 1, 0, 0, 0, 8'h00, 4'h0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 2, 8'hB2, 4'h0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 8'h00, 4'h0));

    // Interleaved lanes 0,1,3 finishing on consecutive edges.
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 8'h00, 4'h0));
    ws = '{8'h11, 8'h22, 8'h33};
    ls = '{2'd0, 2'd1, 2'd3};
    for (int b = 7; b >= 0; b--) begin
      for (int j = 0; j < 3; j++) begin
        w = ws[j];
        v = mk(0, 1, ls[j], w[b], 1, 0, 0, 0, 8'h00, 4'h0);
        if (b == 0 && j == 1) begin v.ev = 1; v.elane = 0; v.edata = 8'h11; end
        if (b == 0 && j == 2) begin v.ev = 1; v.elane = 1; v.edata = 8'h22; end
        tbl.push_back(v);
      end
    end
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 3, 8'h33, 4'h0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 8'h00, 4'h0));

    foreach (tbl[i]) begin
      rst       = tbl[i].rst;
      in_valid  = tbl[i].iv;
      select    = tbl[i].sel;
      lane_bits = lanes_for(tbl[i].sel, tbl[i].bitv);
      out_ready = tbl[i].rdy;
      ovf_clr   = tbl[i].clr;
      step();
      chk_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].elane, tbl[i].edata, tbl[i].eovf);
    end

    // Backpressure on lane 1: third word overflows and is dropped.
    do_reset();
    send_word(1, 8'hA5, 0, 0, 0);
    send_word(1, 8'h5A, 0, 0, 0);
    send_word(1, 8'hFF, 0, 0, 0);
    chk_out("ovf_full", 1, 1, 8'hA5, 4'b0010);
    idle(1, 0);
    chk_out("ovf_drain1", 1, 1, 8'h5A, 4'b0010);
    idle(1, 0);
    chk_out("ovf_drain2", 0, 0, 8'h00, 4'b0010);
    idle(1, 0);
    chk_out("ovf_drain3", 0, 0, 8'h00, 4'b0010);

    // Overflow set on the same edge as ovf_clr: set wins; clear alone clears.
    send_word(1, 8'h11, 0, 0, 0);
    send_word(1, 8'h22, 0, 0, 0);
    send_word(1, 8'h33, 0, 0, 1);
    chk_out("clr_vs_set", 1, 1, 8'h11, 4'b0010);
    idle(0, 1);
    chk_out("clr_alone", 1, 1, 8'h11, 4'b0000);
    idle(1, 0);
    chk_out("clr_drain1", 1, 1, 8'h22, 4'b0000);
    idle(1, 0);
    chk_out("clr_drain2", 0, 0, 8'h00, 4'b0000);

    // Holding drains on the very edge a new word for the same lane completes.
    send_word(1, 8'h0F, 0, 0, 0);
    send_word(1, 8'hF0, 0, 0, 0);
    send_word(1, 8'h69, 0, 1, 0);
    chk_out("same_edge", 1, 1, 8'hF0, 4'b0000);
    idle(1, 0);
    chk_out("same_edge_next", 1, 1, 8'h69, 4'b0000);
    idle(1, 0);
    chk_out("same_edge_done", 0, 0, 8'h00, 4'b0000);

    // out_ready toggling with four words queued.
    do_reset();
    send_word(0, 8'h3C, 0, 0, 0);
    send_word(1, 8'h71, 0, 0, 0);
    send_word(2, 8'h96, 0, 0, 0);
    send_word(3, 8'hE1, 0, 0, 0);
    exp_lane = '{2'd0, 2'd1, 2'd2, 2'd3};
    exp_data = '{8'h3C, 8'h71, 8'h96, 8'hE1};
    for (int c = 0; c < 16; c++) begin
      out_ready = (c % 2 == 0);
      if (out_valid && out_ready) begin
        q_lane.push_back(out_lane);
        q_data.push_back(out_data);
      end
      hold_v = out_valid && !out_ready;
      hold_l = out_lane;
      hold_d = out_data;
      step();
      if (hold_v) begin
        chk($sformatf("toggle%0d.valid", c), 32'(out_valid), 32'd1);
        chk($sformatf("toggle%0d.lane", c), 32'(out_lane), 32'(hold_l));
        chk($sformatf("toggle%0d.data", c), 32'(out_data), 32'(hold_d));
      end
    end
    chk("toggle.count", 32'(q_data.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < q_data.size()) begin
        chk($sformatf("toggle.word%0d.lane", i), 32'(q_lane[i]), 32'(exp_lane[i]));
        chk($sformatf("toggle.word%0d.data", i), 32'(q_data[i]), 32'(exp_data[i]));
      end
    end

    // Reset mid-word on lane 3 discards the partial bits.
    do_reset();
    w = 8'b10111000;
    for (int b = 7; b >= 3; b--) begin
      in_valid = 1'b1; select = 2'd3; lane_bits = lanes_for(2'd3, w[b]); out_ready = 1'b1;
      step();
    end
    rst = 1'b1; in_valid = 1'b1; select = 2'd3; lane_bits = lanes_for(2'd3, 1'b1); ovf_clr = 1'b1;
    step();
    rst = 1'b0; ovf_clr = 1'b0; in_valid = 1'b0;
    chk_out("midrst", 0, 0, 8'h00, 4'h0);
    send_word(3, 8'hC3, 1, 1, 0);
    chk_out("midrst_done", 0, 0, 8'h00, 4'h0);
    idle(1, 0);
    chk_out("midrst_out", 1, 3, 8'hC3, 4'h0);
    idle(1, 0);
    chk_out("midrst_end", 0, 0, 8'h00, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
